// File: rtl/midi_pkg.sv
// Shared MIDI constants, message struct, counter FSM states and byte popcount helper.
// Pure declarations: no latency, no backpressure.
package midi_pkg;
   localparam int NOTE_W = 7;
   localparam int KEYS_W = 128;

   localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
   localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
   localparam logic [3:0] MIDI_CC       = 4'hB;

   localparam logic [NOTE_W-1:0] MIDI_SUSTAIN_CC = 7'd64;
   localparam logic [NOTE_W-1:0] MIDI_ALL_OFF_CC = 7'd123;

   typedef enum logic {IDLE, SCAN} cnt_state_t;

   typedef struct packed {
      logic [3:0]        status;
      logic [3:0]        chan;
      logic [NOTE_W-1:0] note;
      logic [NOTE_W-1:0] lsb;
      logic [NOTE_W-1:0] msb;
   } midi_msg_t;

   function automatic logic [3:0] popcnt8(input logic [7:0] v);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
      return s;
   endfunction
endpackage

// File: rtl/key_popcount.sv
// Slice-serial popcount of a 128-bit vector: result 16 clks after load, load restarts a scan.
// No backpressure: a new load simply abandons the running scan.
module key_popcount
   import midi_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [KEYS_W-1:0] vec_in,
   input  logic              load,
   output logic [7:0]        cnt,
   output logic              valid
);
   cnt_state_t        state_q, state_d;
   logic [KEYS_W-1:0] snap_q, snap_d;
   logic [3:0]        idx_q, idx_d;
   logic [7:0]        acc_q, acc_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [7:0]        slice;
   logic [7:0]        sum;

   assign slice = snap_q[{idx_q, 3'b000} +: 8];
   assign sum   = acc_q + {4'b0000, popcnt8(slice)};

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: ;
         SCAN: begin
            if (idx_q == 4'd15) begin
               cnt_d   = sum;
               valid_d = 1'b1;
               state_d = IDLE;
            end else begin
               acc_d = sum;
               idx_d = idx_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A load wins over a finishing scan: the stale result must never be published.
      if (load) begin
         snap_d  = vec_in;
         idx_d   = '0;
         acc_d   = '0;
         valid_d = 1'b0;
         state_d = SCAN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b1;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign cnt   = cnt_q;
   assign valid = valid_q;
endmodule

// File: rtl/midi_key_tracker.sv
// MIDI strobes -> registered sounding-key mask, 1 clk latency; sustain pedal under MIDI_SUSTAIN_EN.
// No backpressure: each accepted strobe is absorbed in its own cycle.
module midi_key_tracker
   import midi_pkg::*;
#(
   parameter int unsigned       CHAN_SEL   = 16,
   parameter int unsigned       DRUM_CHAN  = 9,
   parameter logic [NOTE_W-1:0] SUSTAIN_CC = MIDI_SUSTAIN_CC,
   parameter logic [NOTE_W-1:0] ALL_OFF_CC = MIDI_ALL_OFF_CC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        ch_message,
   input  logic [3:0]        chan,
   input  logic [NOTE_W-1:0] note,
   input  logic [NOTE_W-1:0] lsb,
   input  logic [NOTE_W-1:0] msb,
   output logic [KEYS_W-1:0] keys,
   output logic              gate,
   output logic              trig,
   output logic [NOTE_W-1:0] last_note,
   output logic              sustain,
   output logic [7:0]        active_cnt,
   output logic              cnt_valid
);
   midi_msg_t msg;
   logic      accept, is_on, is_off, is_cc, is_alloff, is_sus;

   logic [KEYS_W-1:0] held_q, held_d;
   logic [KEYS_W-1:0] keys_q, keys_d;
   logic              gate_q, trig_q, trig_d;
   logic [NOTE_W-1:0] last_q, last_d;
   logic              keys_chg;

   assign msg = '{status: ch_message, chan: chan, note: note, lsb: lsb, msb: msb};

   // DRUM_CHAN = 16 can never match a 4-bit channel, which disables the exclusion.
   assign accept = msg.status[3]
                   && ({1'b0, msg.chan} != 5'(DRUM_CHAN))
                   && ((CHAN_SEL == 16) || ({1'b0, msg.chan} == 5'(CHAN_SEL)));

   assign is_on     = accept && (msg.status == MIDI_NOTE_ON) && (msg.lsb != '0);
   assign is_off    = accept && ((msg.status == MIDI_NOTE_OFF)
                                 || ((msg.status == MIDI_NOTE_ON) && (msg.lsb == '0)));
   assign is_cc     = accept && (msg.status == MIDI_CC);
   assign is_alloff = is_cc && (msg.lsb == ALL_OFF_CC);
   assign is_sus    = is_cc && (msg.lsb == SUSTAIN_CC);

   always_comb begin
      held_d = held_q;
      trig_d = 1'b0;
      last_d = last_q;
      if (is_on) begin
         held_d[msg.note] = 1'b1;
         trig_d           = 1'b1;
         last_d           = msg.note;
      end else if (is_off) begin
         held_d[msg.note] = 1'b0;
      end else if (is_alloff) begin
         held_d = '0;
      end
   end

`ifdef MIDI_SUSTAIN_EN
   logic [KEYS_W-1:0] sust_q, sust_d;
   logic              sustain_q, sustain_d;

   always_comb begin
      sust_d    = sust_q;
      sustain_d = sustain_q;
      if (is_on) begin
         sust_d[msg.note] = 1'b0;
      end else if (is_off) begin
         // Releasing a key that is not held leaves its sustained state alone.
         if (sustain_q && held_q[msg.note]) sust_d[msg.note] = 1'b1;
      end else if (is_alloff) begin
         sust_d = '0;
      end else if (is_sus) begin
         sustain_d = msg.msb[6];
         if (sustain_q && !sustain_d) sust_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sust_q    <= '0;
         sustain_q <= 1'b0;
      end else begin
         sust_q    <= sust_d;
         sustain_q <= sustain_d;
      end
   end

   assign keys_d  = held_d | sust_d;
   assign sustain = sustain_q;
`else
   logic unused_sus;
   assign unused_sus = ^{msg.msb, is_sus};
   assign keys_d     = held_d;
   assign sustain    = 1'b0;
`endif

   assign keys_chg = (keys_d != keys_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q <= '0;
         keys_q <= '0;
         gate_q <= 1'b0;
         trig_q <= 1'b0;
         last_q <= '0;
      end else begin
         held_q <= held_d;
         keys_q <= keys_d;
         gate_q <= |keys_d;
         trig_q <= trig_d;
         last_q <= last_d;
      end
   end

   key_popcount u_popcount (
      .clk    (clk),
      .rst_n  (rst_n),
      .vec_in (keys_d),
      .load   (keys_chg),
      .cnt    (active_cnt),
      .valid  (cnt_valid)
   );

   assign keys      = keys_q;
   assign gate      = gate_q;
   assign trig      = trig_q;
   assign last_note = last_q;
endmodule

// File: tb/tb_midi_key_tracker.sv
// Directed bench for midi_key_tracker: vector table plus hand sequences for scan timing and reset.
module tb_midi_key_tracker;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   ch_message, chan;
   logic [6:0]   note, lsb, msb;

   logic [127:0] keys, keys2;
   logic         gate, trig, sustain, cnt_valid;
   logic         gate2, trig2, sustain2, cnt_valid2;
   logic [6:0]   last_note, last_note2;
   logic [7:0]   active_cnt, active_cnt2;

   int total = 0;
   int bad   = 0;

`ifdef MIDI_SUSTAIN_EN
   localparam bit SUS = 1'b1;
`else
   localparam bit SUS = 1'b0;
`endif

   always #5 clk = ~clk;

   midi_key_tracker dut (
      .clk(clk), .rst_n(rst_n), .ch_message(ch_message), .chan(chan), .note(note),
      .lsb(lsb), .msb(msb), .keys(keys), .gate(gate), .trig(trig),
      .last_note(last_note), .sustain(sustain), .active_cnt(active_cnt),
      .cnt_valid(cnt_valid)
   );

   midi_key_tracker #(.CHAN_SEL(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .ch_message(ch_message), .chan(chan), .note(note),
      .lsb(lsb), .msb(msb), .keys(keys2), .gate(gate2), .trig(trig2),
      .last_note(last_note2), .sustain(sustain2), .active_cnt(active_cnt2),
      .cnt_valid(cnt_valid2)
   );

   typedef struct {
      logic [3:0]   cm;
      logic [3:0]   ch;
      logic [6:0]   n;
      logic [6:0]   l;
      logic [6:0]   m;
      logic [127:0] k;
      logic         t;
      logic [6:0]   ln;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input logic [3:0] cm, input logic [3:0] ch, input logic [6:0] n,
                               input logic [6:0] l, input logic [6:0] m, input logic [127:0] k,
                               input logic t, input logic [6:0] ln);
      vec_t v;
      v.cm = cm; v.ch = ch; v.n = n; v.l = l; v.m = m; v.k = k; v.t = t; v.ln = ln;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; drives one strobe and returns at the negedge after it was captured.
   task automatic send(input logic [3:0] cm, input logic [3:0] ch, input logic [6:0] n,
                       input logic [6:0] l, input logic [6:0] m);
      ch_message = cm; chan = ch; note = n; lsb = l; msb = m;
      @(negedge clk);
      ch_message = 4'h0;
   endtask

   // Called just after the edge where keys changed: result must appear exactly 16 clks later.
   task automatic chk_scan(input string name, input logic [7:0] exp);
      repeat (15) @(negedge clk);
      chk({name, "_valid_at15"}, 128'(cnt_valid), 128'(1'b0));
      @(negedge clk);
      chk({name, "_valid_at16"}, 128'(cnt_valid), 128'(1'b1));
      chk({name, "_cnt"}, 128'(active_cnt), 128'(exp));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [127:0] one;
      logic [127:0] all_ones;
      logic         seen_valid;

      one      = 128'd1;
      all_ones = '1;
      rst_n = 1'b0; ch_message = 4'h0; chan = 4'h0; note = '0; lsb = '0; msb = '0;

      tbl[0]  = mk(4'h9, 4'd0,  7'd60,  7'd100, 7'd0, one << 60,                 1'b1, 7'd60);
      tbl[1]  = mk(4'h0, 4'd0,  7'd0,   7'd0,   7'd0, one << 60,                 1'b0, 7'd60);
      tbl[2]  = mk(4'h9, 4'd0,  7'd64,  7'd90,  7'd0, (one << 60) | (one << 64), 1'b1, 7'd64);
      tbl[3]  = mk(4'h9, 4'd0,  7'd64,  7'd0,   7'd0, one << 60,                 1'b0, 7'd64);
      tbl[4]  = mk(4'h9, 4'd9,  7'd36,  7'd100, 7'd0, one << 60,                 1'b0, 7'd64);
      tbl[5]  = mk(4'h8, 4'd5,  7'd70,  7'd0,   7'd0, one << 60,                 1'b0, 7'd64);
      tbl[6]  = mk(4'hB, 4'd0,  7'd0,   7'd10,  7'd5, one << 60,                 1'b0, 7'd64);
      tbl[7]  = mk(4'h9, 4'd15, 7'd127, 7'd1,   7'd0, (one << 60) | (one << 127), 1'b1, 7'd127);
      tbl[8]  = mk(4'h8, 4'd0,  7'd127, 7'd40,  7'd0, one << 60,                 1'b0, 7'd127);
      tbl[9]  = mk(4'hA, 4'd0,  7'd61,  7'd50,  7'd0, one << 60,                 1'b0, 7'd127);
      tbl[10] = mk(4'hB, 4'd0,  7'd0,   7'd123, 7'd0, 128'd0,                    1'b0, 7'd127);
      tbl[11] = mk(4'h9, 4'd0,  7'd0,   7'd5,   7'd0, one,                       1'b1, 7'd0);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_keys", keys, 128'd0);
      chk("rst_gate", 128'(gate), 128'(1'b0));
      chk("rst_trig", 128'(trig), 128'(1'b0));
      chk("rst_last", 128'(last_note), 128'(7'd0));
      chk("rst_sustain", 128'(sustain), 128'(1'b0));
      chk("rst_cnt", 128'(active_cnt), 128'(8'd0));
      chk("rst_valid", 128'(cnt_valid), 128'(1'b1));

      for (int i = 0; i < 12; i++) begin
         send(tbl[i].cm, tbl[i].ch, tbl[i].n, tbl[i].l, tbl[i].m);
         chk($sformatf("vec%0d_keys", i), keys, tbl[i].k);
         chk($sformatf("vec%0d_gate", i), 128'(gate), 128'(|tbl[i].k));
         chk($sformatf("vec%0d_trig", i), 128'(trig), 128'(tbl[i].t));
         chk($sformatf("vec%0d_last", i), 128'(last_note), 128'(tbl[i].ln));
      end
      chk_scan("single", 8'd1);

      // Sustain pedal: held note survives its note-off only when the pedal feature is built in.
      do_reset();
      send(4'hB, 4'd0, 7'd0, 7'd64, 7'd127);
      chk("sus_on", 128'(sustain), 128'(SUS));
      send(4'h9, 4'd0, 7'd48, 7'd100, 7'd0);
      chk("sus_noteon_keys", keys, one << 48);
      send(4'h8, 4'd0, 7'd48, 7'd0, 7'd0);
      chk("sus_noteoff_keys", keys, SUS ? (one << 48) : 128'd0);
      send(4'hB, 4'd0, 7'd0, 7'd64, 7'd0);
      chk("sus_release_keys", keys, 128'd0);
      chk("sus_release_gate", 128'(gate), 128'(1'b0));
      chk("sus_off", 128'(sustain), 128'(1'b0));

      // Channel filter on the CHAN_SEL=2 instance.
      do_reset();
      send(4'h9, 4'd3, 7'd36, 7'd100, 7'd0);
      chk("chsel_other_keys", keys2, 128'd0);
      chk("chsel_other_trig", 128'(trig2), 128'(1'b0));
      send(4'h9, 4'd2, 7'd36, 7'd100, 7'd0);
      chk("chsel_match_keys", keys2, one << 36);
      chk("chsel_match_trig", 128'(trig2), 128'(1'b1));

      // Fill every key two clocks apart: each change restarts the scan.
      do_reset();
      seen_valid = 1'b0;
      for (int n = 0; n < 128; n++) begin
         send(4'h9, 4'd0, 7'(n), 7'd64, 7'd0);
         if (cnt_valid) seen_valid = 1'b1;
         if (n != 127) begin
            @(negedge clk);
            if (cnt_valid) seen_valid = 1'b1;
         end
      end
      chk("fill_valid_low", 128'(seen_valid), 128'(1'b0));
      chk("fill_keys", keys, all_ones);
      chk("fill_last", 128'(last_note), 128'(7'd127));
      chk_scan("fill", 8'd128);
      send(4'hB, 4'd0, 7'd0, 7'd123, 7'd0);
      chk("alloff_keys", keys, 128'd0);
      chk_scan("alloff", 8'd0);

      // Reset in the middle of a scan while a previous count is still displayed.
      do_reset();
      for (int n = 1; n <= 5; n++) send(4'h9, 4'd0, 7'(n), 7'd64, 7'd0);
      chk_scan("five", 8'd5);
      send(4'h9, 4'd0, 7'd6, 7'd64, 7'd0);
      repeat (3) @(negedge clk);
      chk("midscan_valid", 128'(cnt_valid), 128'(1'b0));
      chk("midscan_hold_cnt", 128'(active_cnt), 128'(8'd5));
      rst_n = 1'b0;
      #1;
      chk("arst_keys", keys, 128'd0);
      chk("arst_cnt", 128'(active_cnt), 128'(8'd0));
      chk("arst_valid", 128'(cnt_valid), 128'(1'b1));
      chk("arst_gate", 128'(gate), 128'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
